// File: rtl/html_tokenizer_pkg.sv
// Shared types and constants for the HTML tokenizer: token codes, tag/attribute ids,
// FSM state encoding, name-buffer geometry and small character helpers.
package html_tokenizer_pkg;

   localparam int CHAR_BITS  = 8;
   localparam int NAME_CHARS = 8;
   localparam int NAME_BITS  = NAME_CHARS * CHAR_BITS;

   typedef logic [CHAR_BITS-1:0] char_t;
   typedef logic [NAME_BITS-1:0] name_t;

   typedef enum logic [2:0] {
      TOK_NONE  = 3'd0,
      TOK_TEXT  = 3'd1,
      TOK_OPEN  = 3'd2,
      TOK_CLOSE = 3'd3,
      TOK_ATTR  = 3'd4,
      TOK_END   = 3'd5
   } token_type_e;

   typedef struct packed {
      token_type_e kind;
      logic [3:0]  tag;
      logic [3:0]  attr;
      logic [7:0]  value;
   } token_t;

   typedef enum logic [3:0] {
      S_IDLE, S_TEXT, S_TAG_OPEN, S_TAG_NAME, S_CLOSE_NAME,
      S_TAG_SPACE, S_ATTR_NAME, S_ATTR_VALUE, S_DONE
   } state_e;

   typedef enum logic {KIND_TAG, KIND_ATTR} name_kind_e;

   localparam logic [3:0] ID_UNKNOWN = 4'd0;
   localparam logic [3:0] TAG_BODY   = 4'd1;
   localparam logic [3:0] TAG_P      = 4'd2;
   localparam logic [3:0] ATTR_COLOR = 4'd1;
   localparam logic [3:0] ATTR_SIZE  = 4'd2;

   // Names are shifted in from the right, so a short name is its string zero-extended.
   localparam name_t NAME_BODY  = {32'd0, "body"};
   localparam name_t NAME_P     = {56'd0, "p"};
   localparam name_t NAME_COLOR = {24'd0, "color"};
   localparam name_t NAME_SIZE  = {32'd0, "size"};

   localparam char_t CH_NUL   = 8'h00;
   localparam char_t CH_SPACE = 8'h20;
   localparam char_t CH_SLASH = 8'h2F;
   localparam char_t CH_LT    = 8'h3C;
   localparam char_t CH_EQ    = 8'h3D;
   localparam char_t CH_GT    = 8'h3E;

   function automatic logic is_letter(char_t c);
      return (c >= "a" && c <= "z") || (c >= "A" && c <= "Z");
   endfunction

   function automatic logic is_digit(char_t c);
      return (c >= "0" && c <= "9");
   endfunction

   function automatic name_t name_push(name_t name, char_t c);
      if (name[NAME_BITS-1 -: CHAR_BITS] != '0) return name;
      return {name[NAME_BITS-CHAR_BITS-1:0], c};
   endfunction

   function automatic logic [7:0] value_push(logic [7:0] value, char_t c);
      logic [11:0] acc;
      acc = 12'(value) * 12'd10 + 12'(c - "0");
      return (acc > 12'd255) ? 8'hFF : acc[7:0];
   endfunction

endpackage

// File: rtl/html_tokenizer_if.sv
// Reader/token handshake bundle; master is the environment, slave is the tokenizer.
interface html_tokenizer_if;
   import html_tokenizer_pkg::*;

   logic       state_enable;
   char_t      char;
   logic       source_finished;
   logic       token_ready;
   logic       pause;
   logic       token_valid;
   logic [2:0] token_type;
   logic [3:0] token_tag;
   logic [3:0] token_attr;
   logic [7:0] token_value;
   logic       has_finished;

   modport master (
      output state_enable, char, source_finished, token_ready,
      input  pause, token_valid, token_type, token_tag, token_attr, token_value, has_finished
   );

   modport slave (
      input  state_enable, char, source_finished, token_ready,
      output pause, token_valid, token_type, token_tag, token_attr, token_value, has_finished
   );

endinterface

// File: rtl/html_name_lookup.sv
// Combinational name-buffer to id matcher; KIND selects the tag or attribute table.
module html_name_lookup
   import html_tokenizer_pkg::*;
#(
   parameter name_kind_e KIND = KIND_TAG
)(
   input  name_t      name,
   output logic [3:0] id
);

   // NOTE: assign every always_comb output a default first so no path infers a latch.
   always_comb begin
      id = ID_UNKNOWN;
      if (KIND == KIND_TAG) begin
         if (name == NAME_BODY)   id = TAG_BODY;
         else if (name == NAME_P) id = TAG_P;
      end else begin
         if (name == NAME_COLOR)     id = ATTR_COLOR;
         else if (name == NAME_SIZE) id = ATTR_SIZE;
      end
   end

endmodule

// File: rtl/html_tokenizer.sv
// Streaming HTML tokenizer: consumes one pending reader char at a time and presents
// OPEN/CLOSE/ATTR/TEXT/END tokens on a valid/ready output, pausing the reader meanwhile.
module html_tokenizer
   import html_tokenizer_pkg::*;
(
   input logic            clock,
   input logic            resetn,
   html_tokenizer_if.slave bus
);

   state_e     state, state_next, recover_state;
   name_t      name_q, name_next;
   logic [7:0] value_q, value_next;
   logic       char_pending, pending_next;
   logic       tok_valid_q, tok_valid_next;
   token_t     tok_q, tok_next, emit_tok;
   logic       emit;
   logic       pause_q;
   logic       finished_q, finished_next;
   logic [3:0] tag_id, attr_id;
   char_t      c;
   logic       advance, slot_free, consume, source_end;

   html_name_lookup #(.KIND(KIND_TAG))  u_tag_lookup  (.name(name_q), .id(tag_id));
   html_name_lookup #(.KIND(KIND_ATTR)) u_attr_lookup (.name(name_q), .id(attr_id));

   assign c          = bus.char;
   assign advance    = bus.state_enable & ~pause_q & ~bus.source_finished;
   assign slot_free  = ~tok_valid_q | bus.token_ready;
   assign consume    = bus.state_enable & char_pending & slot_free;
   assign source_end = bus.state_enable & bus.source_finished & ~char_pending
                       & slot_free & (state != S_DONE);
   // A stray '<' inside a tag is re-read as the start of a fresh tag.
   assign recover_state = (c == CH_LT) ? S_TAG_OPEN : S_TEXT;

   always_comb begin
      state_next = state;
      name_next  = name_q;
      value_next = value_q;
      emit       = 1'b0;
      emit_tok   = '0;
      if (consume && state != S_DONE) begin
         if (c == CH_NUL) begin
            emit          = 1'b1;
            emit_tok.kind = TOK_END;
            state_next    = S_DONE;
         end else begin
            case (state)
               S_IDLE, S_TEXT: begin
                  if (c == CH_LT) begin
                     state_next = S_TAG_OPEN;
                  end else begin
                     state_next     = S_TEXT;
                     emit           = 1'b1;
                     emit_tok.kind  = TOK_TEXT;
                     emit_tok.value = c;
                  end
               end
               S_TAG_OPEN: begin
                  if (c == CH_SLASH) begin
                     state_next = S_CLOSE_NAME;
                     name_next  = '0;
                  end else if (is_letter(c)) begin
                     state_next = S_TAG_NAME;
                     name_next  = name_push('0, c);
                  end else begin
                     state_next = recover_state;
                  end
               end
               S_TAG_NAME, S_CLOSE_NAME: begin
                  if (is_letter(c) || is_digit(c)) begin
                     name_next = name_push(name_q, c);
                  end else if (c == CH_GT || (c == CH_SPACE && state == S_TAG_NAME)) begin
                     state_next    = (c == CH_GT) ? S_TEXT : S_TAG_SPACE;
                     emit          = 1'b1;
                     emit_tok.kind = (state == S_TAG_NAME) ? TOK_OPEN : TOK_CLOSE;
                     emit_tok.tag  = tag_id;
                  end else begin
                     state_next = recover_state;
                  end
               end
               S_TAG_SPACE: begin
                  if (is_letter(c)) begin
                     state_next = S_ATTR_NAME;
                     name_next  = name_push('0, c);
                  end else if (c == CH_GT) begin
                     state_next = S_TEXT;
                  end else if (c != CH_SPACE) begin
                     state_next = recover_state;
                  end
               end
               S_ATTR_NAME: begin
                  if (is_letter(c)) begin
                     name_next = name_push(name_q, c);
                  end else if (c == CH_EQ) begin
                     state_next = S_ATTR_VALUE;
                     value_next = '0;
                  end else begin
                     state_next = recover_state;
                  end
               end
               S_ATTR_VALUE: begin
                  if (is_digit(c)) begin
                     value_next = value_push(value_q, c);
                  end else if (c == CH_SPACE || c == CH_GT) begin
                     state_next     = (c == CH_GT) ? S_TEXT : S_TAG_SPACE;
                     emit           = 1'b1;
                     emit_tok.kind  = TOK_ATTR;
                     emit_tok.attr  = attr_id;
                     emit_tok.value = value_q;
                  end else begin
                     state_next = recover_state;
                  end
               end
               default: state_next = recover_state;
            endcase
         end
      end else if (source_end) begin
         emit          = 1'b1;
         emit_tok.kind = TOK_END;
         state_next    = S_DONE;
      end
   end

   always_comb begin
      tok_valid_next = tok_valid_q;
      tok_next       = tok_q;
      if (emit) begin
         tok_valid_next = 1'b1;
         tok_next       = emit_tok;
      end else if (bus.token_ready) begin
         tok_valid_next = 1'b0;
      end
      pending_next  = advance | (char_pending & ~consume);
      finished_next = finished_q | ((state == S_DONE) & tok_valid_q & bus.token_ready);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state        <= S_IDLE;
         name_q       <= '0;
         value_q      <= '0;
         char_pending <= 1'b0;
         tok_valid_q  <= 1'b0;
         tok_q        <= '0;
         pause_q      <= 1'b0;
         finished_q   <= 1'b0;
      end else if (!bus.state_enable) begin
         state        <= S_IDLE;
         name_q       <= '0;
         value_q      <= '0;
         char_pending <= 1'b0;
         tok_valid_q  <= 1'b0;
         tok_q        <= '0;
         pause_q      <= 1'b0;
         finished_q   <= 1'b0;
      end else begin
         state        <= state_next;
         name_q       <= name_next;
         value_q      <= value_next;
         char_pending <= pending_next;
         tok_valid_q  <= tok_valid_next;
         tok_q        <= tok_next;
         pause_q      <= tok_valid_next;
         finished_q   <= finished_next;
      end
   end

   assign bus.pause        = pause_q;
   assign bus.token_valid  = tok_valid_q;
   assign bus.token_type   = tok_q.kind;
   assign bus.token_tag    = tok_q.tag;
   assign bus.token_attr   = tok_q.attr;
   assign bus.token_value  = tok_q.value;
   assign bus.has_finished = finished_q;

endmodule

// File: tb/tb_html_tokenizer.sv
// Self-checking bench: a reader model feeds strings, a scoreboard queue holds expected tokens.
module tb_html_tokenizer;
   import html_tokenizer_pkg::*;

   typedef struct packed {
      logic [2:0] kind;
      logic [3:0] tag;
      logic [3:0] attr;
      logic [7:0] value;
   } exp_t;

   logic clock  = 1'b0;
   logic resetn = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   exp_t exp_q[$];

   html_tokenizer_if bus ();

   html_tokenizer dut (
      .clock (clock),
      .resetn(resetn),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   function automatic void push_tok(logic [2:0] kind, logic [3:0] tag, logic [3:0] attr,
                                    logic [7:0] value);
      exp_t e;
      e.kind = kind; e.tag = tag; e.attr = attr; e.value = value;
      exp_q.push_back(e);
   endfunction

   function automatic logic [18:0] outputs_now();
      return {bus.token_valid, bus.pause, bus.has_finished, bus.token_type,
              bus.token_tag, bus.token_attr, bus.token_value};
   endfunction

   task automatic clear_dut();
      @(negedge clock);
      bus.state_enable    = 1'b0;
      bus.token_ready     = 1'b0;
      bus.source_finished = 1'b0;
      bus.char            = 8'h00;
      @(negedge clock);
   endtask

   // mode 0: ready always; mode 1: ready one cycle in three; mode 2: never ready.
   task automatic run_stream(input string s, input bit add_nul, input int mode,
                             input int min_cycles);
      int   idx;
      int   total;
      bit   adv;
      bit   hold;
      exp_t held;
      exp_t cur;
      exp_t e;
      exp_t mask;
      idx   = -1;
      total = s.len() + (add_nul ? 1 : 0);
      hold  = 1'b0;
      held  = '0;
      bus.state_enable    = 1'b1;
      bus.char            = 8'h00;
      bus.source_finished = (total == 0);
      bus.token_ready     = 1'b0;
      adv = bus.state_enable & !bus.pause & !bus.source_finished;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         @(negedge clock);
         if (adv) begin
            idx++;
            bus.char            = (idx < s.len()) ? s[idx] : 8'h00;
            bus.source_finished = (idx >= total - 1);
         end
         case (mode)
            0:       bus.token_ready = 1'b1;
            1:       bus.token_ready = (cyc % 3 == 0);
            default: bus.token_ready = 1'b0;
         endcase
         checks++;
         if (bus.pause !== bus.token_valid) begin
            failures++;
            $display("FAIL pause_vs_valid: pause=%b token_valid=%b (must match) cyc=%0d",
                     bus.pause, bus.token_valid, cyc);
         end
         cur = {bus.token_type, bus.token_tag, bus.token_attr, bus.token_value};
         if (hold) begin
            checks++;
            if (bus.token_valid !== 1'b1 || cur !== held) begin
               failures++;
               $display("FAIL token_hold: valid=%b token=%h, required valid=1 token=%h",
                        bus.token_valid, cur, held);
            end
         end
         if (bus.token_valid === 1'b1 && bus.token_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_token: got type=%0d tag=%0d attr=%0d value=%h, none expected",
                        bus.token_type, bus.token_tag, bus.token_attr, bus.token_value);
            end else begin
               e    = exp_q.pop_front();
               mask = '0;
               mask.kind = 3'b111;
               case (e.kind)
                  3'd1:       mask.value = 8'hFF;
                  3'd2, 3'd3: mask.tag   = 4'hF;
                  3'd4: begin mask.attr = 4'hF; mask.value = 8'hFF; end
                  default: ;
               endcase
               if ((cur & mask) !== (e & mask)) begin
                  failures++;
                  $display("FAIL token: got type=%0d tag=%0d attr=%0d value=%h, required type=%0d tag=%0d attr=%0d value=%h",
                           bus.token_type, bus.token_tag, bus.token_attr, bus.token_value,
                           e.kind, e.tag, e.attr, e.value);
               end
            end
         end
         hold = bus.token_valid & !bus.token_ready;
         held = cur;
         adv  = bus.state_enable & !bus.pause & !bus.source_finished;
         if (exp_q.size() == 0 && cyc >= min_cycles) break;
      end
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL stream_timeout: %0d tokens still outstanding for '%s', required 0",
                  exp_q.size(), s);
         exp_q.delete();
      end
   endtask

   task automatic push_main_sequence();
      push_tok(3'd2, 4'd1, 4'd0, 8'd0);
      push_tok(3'd2, 4'd2, 4'd0, 8'd0);
      push_tok(3'd4, 4'd0, 4'd1, 8'd1);
      push_tok(3'd4, 4'd0, 4'd2, 8'd2);
      push_tok(3'd1, 4'd0, 4'd0, "t");
      push_tok(3'd1, 4'd0, 4'd0, "e");
      push_tok(3'd1, 4'd0, 4'd0, "s");
      push_tok(3'd1, 4'd0, 4'd0, "t");
      push_tok(3'd3, 4'd2, 4'd0, 8'd0);
      push_tok(3'd3, 4'd1, 4'd0, 8'd0);
      push_tok(3'd5, 4'd0, 4'd0, 8'd0);
   endtask

   task automatic check_finished(input string name);
      @(negedge clock);
      checks++;
      if (bus.has_finished !== 1'b1) begin
         failures++;
         $display("FAIL %s_finished: has_finished=%b, required 1", name, bus.has_finished);
      end
   endtask

   task automatic test_reset();
      bus.state_enable    = 1'b0;
      bus.token_ready     = 1'b0;
      bus.source_finished = 1'b0;
      bus.char            = 8'h00;
      #1 resetn = 1'b0;
      #1;
      checks++;
      if (outputs_now() !== '0) begin
         failures++;
         $display("FAIL reset_outputs: outputs=%h, required 0", outputs_now());
      end
      @(negedge clock);
      resetn = 1'b1;
   endtask

   task automatic test_stream_ready();
      clear_dut();
      push_main_sequence();
      run_stream("<body><p color=1 size=2 >test</p></body>", 1'b1, 0, 0);
      check_finished("stream_ready");
   endtask

   task automatic test_back_pressure();
      clear_dut();
      push_main_sequence();
      run_stream("<body><p color=1 size=2 >test</p></body>", 1'b1, 1, 0);
      check_finished("back_pressure");
   endtask

   task automatic test_saturation();
      clear_dut();
      push_tok(3'd2, 4'd2, 4'd0, 8'd0);
      push_tok(3'd4, 4'd0, 4'd2, 8'd255);
      push_tok(3'd5, 4'd0, 4'd0, 8'd0);
      run_stream("<p size=300>", 1'b0, 0, 0);
      check_finished("saturation");
   endtask

   task automatic test_unknown_tag();
      clear_dut();
      push_tok(3'd2, 4'd0, 4'd0, 8'd0);
      push_tok(3'd5, 4'd0, 4'd0, 8'd0);
      run_stream("<xyz>", 1'b0, 0, 0);
      check_finished("unknown_tag");
   endtask

   task automatic test_enable_clear();
      clear_dut();
      push_tok(3'd2, 4'd2, 4'd0, 8'd0);
      run_stream("<p>a", 1'b0, 0, 0);
      bus.state_enable = 1'b0;
      bus.token_ready  = 1'b0;
      @(negedge clock);
      checks++;
      if (outputs_now() !== '0) begin
         failures++;
         $display("FAIL enable_clear_outputs: outputs=%h, required 0", outputs_now());
      end
      checks++;
      if (dut.state !== S_IDLE || dut.char_pending !== 1'b0) begin
         failures++;
         $display("FAIL enable_clear_state: state=%0d pending=%b, required IDLE and 0",
                  dut.state, dut.char_pending);
      end
   endtask

   task automatic test_async_reset();
      clear_dut();
      run_stream("<p>", 1'b0, 2, 10);
      checks++;
      if (bus.token_valid !== 1'b1) begin
         failures++;
         $display("FAIL async_reset_setup: token_valid=%b, required 1", bus.token_valid);
      end
      #1 resetn = 1'b0;
      #1;
      checks++;
      if (outputs_now() !== '0) begin
         failures++;
         $display("FAIL async_reset_outputs: outputs=%h, required 0", outputs_now());
      end
      @(negedge clock);
      resetn = 1'b1;
   endtask

   task automatic test_malformed();
      clear_dut();
      push_tok(3'd2, 4'd2, 4'd0, 8'd0);
      push_tok(3'd5, 4'd0, 4'd0, 8'd0);
      run_stream("<<p>", 1'b0, 0, 0);
      check_finished("malformed");
   endtask

   initial begin
      test_reset();
      test_stream_ready();
      test_back_pressure();
      test_saturation();
      test_unknown_tag();
      test_enable_clear();
      test_async_reset();
      test_malformed();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
